// File: rtl/time_display_driver_pkg.sv
// Shared constants for the time display driver: FSM encodings, glyphs, digit count.
// Ports: none (package); also holds the double-dabble nibble adjust and glyph lookup helpers.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the output registers.
package time_display_driver_pkg;

  localparam int DIGITS = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CONV_S = 3'd2;
  localparam logic [2:0] ST_CONV_M = 3'd3;
  localparam logic [2:0] ST_CONV_H = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  localparam logic [6:0] GLYPH_0    = 7'b0111111;
  localparam logic [6:0] GLYPH_1    = 7'b0000110;
  localparam logic [6:0] GLYPH_2    = 7'b1011011;
  localparam logic [6:0] GLYPH_3    = 7'b1001111;
  localparam logic [6:0] GLYPH_4    = 7'b1100110;
  localparam logic [6:0] GLYPH_5    = 7'b1101101;
  localparam logic [6:0] GLYPH_6    = 7'b1111101;
  localparam logic [6:0] GLYPH_7    = 7'b0000111;
  localparam logic [6:0] GLYPH_8    = 7'b1111111;
  localparam logic [6:0] GLYPH_9    = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

  // Stored digit code for a dashed position (any code above 9 renders as a dash).
  localparam logic [3:0] DASH_CODE = 4'hF;

  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_DASH;
    endcase
  endfunction

endpackage

// File: rtl/time_display_driver_bin2bcd_seq.sv
// 8-bit sequential double-dabble: start loads value, 8 steps follow, done marks the last step.
// Ports: clock/reset, start + value in; done + bcd out (bcd is the result of the current step,
// valid as the final {hundreds,tens,units} while done=1). A start always wins over a running step.
module bin2bcd_seq
  import time_display_driver_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  value,
  output logic        done,
  output logic [11:0] bcd
);

  // work = {scratch[11:0], shift[7:0]}
  logic [19:0] work;
  logic [19:0] step;
  logic [11:0] adj;
  logic [2:0]  cnt;
  logic        running;

  assign adj  = {dd_adjust(work[19:16]), dd_adjust(work[15:12]), dd_adjust(work[11:8])};
  assign step = {adj, work[7:0]} << 1;
  assign bcd  = step[19:8];
  assign done = running && (cnt == 3'd7);

  always_ff @(posedge clock) begin
    if (reset) begin
      work    <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      work    <= {12'd0, value};
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      work <= step;
      cnt  <= cnt + 3'd1;
      if (cnt == 3'd7) running <= 1'b0;
    end
  end

endmodule

// File: rtl/time_display_driver.sv
// Snapshots h/m/s on update, converts to BCD with one shared sequential unit, scans HH.MM.SS.
// Ports: clock/reset; seconds/minutes/hours/update in; seg/dp/digit_en (scan), busy, range_err out.
// Commit lands 26 cycles after the sampled update; updates while busy are held as one pending set.
module time_display_driver
  import time_display_driver_pkg::*;
#(
  parameter int SCAN_DIV       = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  seconds,
  input  logic [7:0]  minutes,
  input  logic [7:0]  hours,
  input  logic        update,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  digit_en,
  output logic        busy,
  output logic        range_err
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0] EN_INV  = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic       DP_INV  = SEG_ACTIVE_LOW;

  logic [2:0]  state;
  logic [7:0]  sh_s, sh_m, sh_h;
  logic [7:0]  pd_s, pd_m, pd_h;
  logic        pending;
  logic [11:0] bcd_s, bcd_m, bcd_h;
  logic [DIGITS*4-1:0] digits;
  logic        err_q;

  logic        conv_start;
  logic [7:0]  conv_value;
  logic        conv_done;
  logic [11:0] conv_bcd;

  logic [PRESC_W-1:0] presc;
  logic [2:0]  idx;
  logic [3:0]  cur_digit;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [5:0]  en_q;

  assign busy      = (state != ST_IDLE);
  assign range_err = err_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_en  = en_q;

  // Two display digits {tens,units}; a nonzero hundreds digit dashes the pair.
  function automatic logic [7:0] pair(input logic [11:0] b);
    return (b[11:8] != 4'd0) ? {DASH_CODE, DASH_CODE} : b[7:0];
  endfunction

  // Next value is launched in the same cycle the previous one finishes.
  always_comb begin
    conv_start = 1'b0;
    conv_value = sh_s;
    case (state)
      ST_LOAD:   conv_start = 1'b1;
      ST_CONV_S: begin conv_start = conv_done; conv_value = sh_m; end
      ST_CONV_M: begin conv_start = conv_done; conv_value = sh_h; end
      default:   conv_start = 1'b0;
    endcase
  end

  bin2bcd_seq u_bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .value (conv_value),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      sh_s    <= '0; sh_m <= '0; sh_h <= '0;
      pd_s    <= '0; pd_m <= '0; pd_h <= '0;
      pending <= 1'b0;
      bcd_s   <= '0; bcd_m <= '0; bcd_h <= '0;
      digits  <= '0;
      err_q   <= 1'b0;
    end else begin
      // Updates arriving mid-conversion park here; COMMIT takes its own update directly.
      if (update && state != ST_IDLE && state != ST_COMMIT) begin
        pd_s    <= seconds;
        pd_m    <= minutes;
        pd_h    <= hours;
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: if (update) begin
          sh_s  <= seconds; sh_m <= minutes; sh_h <= hours;
          state <= ST_LOAD;
        end
        ST_LOAD: state <= ST_CONV_S;
        ST_CONV_S: if (conv_done) begin bcd_s <= conv_bcd; state <= ST_CONV_M; end
        ST_CONV_M: if (conv_done) begin bcd_m <= conv_bcd; state <= ST_CONV_H; end
        ST_CONV_H: if (conv_done) begin bcd_h <= conv_bcd; state <= ST_COMMIT; end
        ST_COMMIT: begin
          digits  <= {pair(bcd_h), pair(bcd_m), pair(bcd_s)};
          err_q   <= (bcd_h[11:8] != 4'd0) || (bcd_m[11:8] != 4'd0) || (bcd_s[11:8] != 4'd0);
          pending <= 1'b0;
          if (update) begin
            // Newer than anything pending, so it wins outright.
            sh_s  <= seconds; sh_m <= minutes; sh_h <= hours;
            state <= ST_LOAD;
          end else if (pending) begin
            sh_s  <= pd_s; sh_m <= pd_m; sh_h <= pd_h;
            state <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running scan, independent of the conversion FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign cur_digit = digits[{idx, 2'b00} +: 4];

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= GLYPH_0 ^ SEG_INV;
      en_q  <= 6'b000001 ^ EN_INV;
      dp_q  <= 1'b0 ^ DP_INV;
    end else begin
      seg_q <= glyph(cur_digit) ^ SEG_INV;
      en_q  <= (6'b000001 << idx) ^ EN_INV;
      // Separator dots sit after the hours and minutes pairs.
      dp_q  <= ((idx == 3'd2) || (idx == 3'd4)) ^ DP_INV;
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
module tb_time_display_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] seconds, minutes, hours;
  logic       update;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digit_en;
  logic       busy;
  logic       range_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [41:0] segs;
    logic        rerr;
  } exp_t;

  exp_t sb[$];

  logic [6:0] disp [6];
  logic       dpv  [6];
  logic       watch_two = 1'b0;
  logic       saw_two = 1'b0;

  time_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .update    (update),
    .seg       (seg),
    .dp        (dp),
    .digit_en  (digit_en),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reconstruct what the viewer sees from the multiplexed outputs.
  always @(negedge clock) begin
    for (int i = 0; i < 6; i++) begin
      logic [5:0] sel;
      sel = ~(6'b000001 << i);
      if (digit_en === sel) begin
        disp[i] = seg;
        dpv[i]  = dp;
      end
    end
    if (watch_two && seg === ~7'b1011011) saw_two = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] gl(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic exp_t model(input int h, input int m, input int s);
    exp_t e;
    int v[3];
    v[0] = s; v[1] = m; v[2] = h;
    e.rerr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (v[k] > 99) begin
        e.rerr = 1'b1;
        e.segs[(2*k)*7 +: 7]   = ~gl(-1);
        e.segs[(2*k+1)*7 +: 7] = ~gl(-1);
      end else begin
        e.segs[(2*k)*7 +: 7]   = ~gl(v[k] % 10);
        e.segs[(2*k+1)*7 +: 7] = ~gl(v[k] / 10);
      end
    end
    return e;
  endfunction

  task automatic do_update(input int h, input int m, input int s);
    hours = 8'(h); minutes = 8'(m); seconds = 8'(s);
    update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int t0, input int exp_lat);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_lat"}, cyc - t0, exp_lat);
  endtask

  task automatic check_commit(input string tag);
    exp_t e;
    check({tag, "_sbq"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rerr"}, range_err, e.rerr);
      repeat (30) @(posedge clock);
      #1;
      for (int i = 0; i < 6; i++) begin
        check($sformatf("%s_seg%0d", tag, i), disp[i], e.segs[i*7 +: 7]);
        check($sformatf("%s_dp%0d", tag, i), dpv[i], (i == 2 || i == 4) ? 1'b0 : 1'b1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    logic [5:0] prev;
    logic [5:0] want;
    logic       hit;
    logic       busy_seen;

    reset = 1'b1; update = 1'b0; seconds = '0; minutes = '0; hours = '0;

    // 1: reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_en", digit_en, 6'b111110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 0);
    check("rst_rerr", range_err, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 2: normal conversion, latency and digit order
    sb.push_back(model(12, 59, 45));
    do_update(12, 59, 45);
    t0 = cyc;
    check("t2_busy_on", busy, 1);
    wait_idle("t2", t0, 26);
    check_commit("t2");

    // 3: out-of-range hours dash their pair, then clear
    sb.push_back(model(150, 0, 7));
    do_update(150, 0, 7);
    t0 = cyc;
    wait_idle("t3a", t0, 26);
    check_commit("t3a");
    sb.push_back(model(3, 0, 7));
    do_update(3, 0, 7);
    t0 = cyc;
    wait_idle("t3b", t0, 26);
    check_commit("t3b");

    // 4: two updates while busy; only the last survives, one reconversion
    watch_two = 1'b1; saw_two = 1'b0;
    sb.push_back(model(3, 3, 3));
    do_update(1, 1, 1);
    t0 = cyc;
    repeat (4) @(posedge clock);
    #1;
    do_update(2, 2, 2);
    repeat (4) @(posedge clock);
    #1;
    do_update(3, 3, 3);
    wait_idle("t4", t0, 52);
    check_commit("t4");
    check("t4_no_two", saw_two, 0);
    watch_two = 1'b0;

    // 5: scan timing from the start of a digit-0 window
    hit = 1'b0; n = 0;
    prev = digit_en;
    while (!hit && n < 60) begin
      @(posedge clock); #1;
      n++;
      hit = (digit_en == 6'b111110) && (prev != 6'b111110);
      prev = digit_en;
    end
    check("t5_sync", hit, 1);
    for (int c = 0; c < 48; c++) begin
      want = ~(6'b000001 << ((c / 4) % 6));
      check($sformatf("t5_en_c%0d", c), digit_en, want);
      @(posedge clock); #1;
    end

    // 6: reset in the middle of a conversion
    do_update(9, 9, 9);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6_busy", busy, 0);
    sb.delete();
    sb.push_back(model(0, 0, 0));
    busy_seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (busy) busy_seen = 1'b1;
    end
    check("t6_no_commit", busy_seen, 0);
    check_commit("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
